// File: rtl/umai_loopback_mem.sv
// UMAI slave endpoint backed by a flop-array memory: write bursts store beats,
// read bursts return them with backpressure, one command in flight at a time.
module umai_loopback_mem #(
    parameter int DataWidth = 512,
    parameter int AddrWidth = 32,
    parameter int LenWidth  = 6,
    parameter int Depth     = 64,
    parameter int CntWidth  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_umai_wcmd_valid,
    output logic                 o_umai_wcmd_ready,
    input  logic [AddrWidth-1:0] i_umai_wcmd_addr,
    input  logic [LenWidth-1:0]  i_umai_wcmd_len,
    input  logic                 i_umai_rcmd_valid,
    output logic                 o_umai_rcmd_ready,
    input  logic [AddrWidth-1:0] i_umai_rcmd_addr,
    input  logic [LenWidth-1:0]  i_umai_rcmd_len,
    input  logic                 i_umai_wvalid,
    output logic                 o_umai_wready,
    input  logic [DataWidth-1:0] i_umai_wdata,
    output logic                 o_umai_rvalid,
    input  logic                 i_umai_rready,
    output logic [DataWidth-1:0] o_umai_rdata,
    output logic                 o_busy,
    output logic [CntWidth-1:0]  o_wcmd_cnt,
    output logic [CntWidth-1:0]  o_rcmd_cnt
);

    localparam int IdxWidth = $clog2(Depth);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t                 state;
    logic [IdxWidth-1:0]    base;
    logic [LenWidth-1:0]    len;
    logic [LenWidth-1:0]    beat;
    logic                   last_grant_write;
    logic [DataWidth-1:0]   mem [Depth];
    logic [IdxWidth-1:0]    idx;
    logic                   slot_free;
    logic                   wbeat;
    logic                   unused_addr_bits;

    // Upper address bits select nothing; the index wraps modulo Depth.
    assign unused_addr_bits = ^{i_umai_wcmd_addr[AddrWidth-1:IdxWidth],
                                i_umai_rcmd_addr[AddrWidth-1:IdxWidth]};

    // Round-robin: when both commands compete, the side not granted last wins.
    assign o_umai_wcmd_ready = (state == IDLE) && i_umai_wcmd_valid &&
                               (!i_umai_rcmd_valid || !last_grant_write);
    assign o_umai_rcmd_ready = (state == IDLE) && i_umai_rcmd_valid &&
                               (!i_umai_wcmd_valid || last_grant_write);
    assign o_umai_wready     = (state == WRITE);

    assign idx       = base + IdxWidth'(beat);
    assign slot_free = !o_umai_rvalid || i_umai_rready;
    assign wbeat     = (state == WRITE) && i_umai_wvalid;
    assign o_busy    = (state != IDLE) || o_umai_rvalid;

    always_ff @(posedge i_clk) begin
        if (wbeat) begin
            mem[idx] <= i_umai_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state            <= IDLE;
            base             <= '0;
            len              <= '0;
            beat             <= '0;
            last_grant_write <= 1'b0;
            o_umai_rvalid    <= 1'b0;
            o_umai_rdata     <= '0;
            o_wcmd_cnt       <= '0;
            o_rcmd_cnt       <= '0;
        end else begin
            // A held read beat may drain while the FSM has already moved on.
            if (state != READ && i_umai_rready) begin
                o_umai_rvalid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (o_umai_wcmd_ready) begin
                        base             <= i_umai_wcmd_addr[IdxWidth-1:0];
                        len              <= i_umai_wcmd_len;
                        beat             <= '0;
                        last_grant_write <= 1'b1;
                        state            <= WRITE;
                        if (o_wcmd_cnt != '1) begin
                            o_wcmd_cnt <= o_wcmd_cnt + CntWidth'(1);
                        end
                    end else if (o_umai_rcmd_ready) begin
                        base             <= i_umai_rcmd_addr[IdxWidth-1:0];
                        len              <= i_umai_rcmd_len;
                        beat             <= '0;
                        last_grant_write <= 1'b0;
                        state            <= READ;
                        if (o_rcmd_cnt != '1) begin
                            o_rcmd_cnt <= o_rcmd_cnt + CntWidth'(1);
                        end
                    end
                end
                WRITE: begin
                    if (i_umai_wvalid) begin
                        beat <= beat + LenWidth'(1);
                        if (beat == len) begin
                            state <= IDLE;
                        end
                    end
                end
                READ: begin
                    if (slot_free) begin
                        o_umai_rdata  <= mem[idx];
                        o_umai_rvalid <= 1'b1;
                        beat          <= beat + LenWidth'(1);
                        if (beat == len) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/umai_loopback_mem.md
Name: umai_loopback_mem

Overview:
- Parametrised UMAI slave endpoint that terminates one UMAI master channel coming out of aib_top.
- Replaces the simulation-only ready/valid tie-offs at chip top with a real flop-array memory.
- Write bursts store data; read bursts return it with backpressure support.
- One instance per channel. Adds burst sequencing, write/read round-robin arbitration and saturating activity counters.

Parameters:
- DataWidth, 512, width of wdata/rdata in bits.
- AddrWidth, 32, width of command address (beat address, not byte address).
- LenWidth, 6, width of command len field.
- Depth, 64, memory entries (power of 2, >= 2); index = address modulo Depth.
- CntWidth, 16, width of the command counters.

Ports:
- i_clk  input  1  IP clock (same clock as aib_top i_ip_clk for this channel).
- i_rst_n  input  1  asynchronous active-low reset.
- i_umai_wcmd_valid  input  1  write command valid.
- o_umai_wcmd_ready  output  1  write command accepted.
- i_umai_wcmd_addr  input  AddrWidth  write start beat address.
- i_umai_wcmd_len  input  LenWidth  write beats minus one.
- i_umai_rcmd_valid  input  1  read command valid.
- o_umai_rcmd_ready  output  1  read command accepted.
- i_umai_rcmd_addr  input  AddrWidth  read start beat address.
- i_umai_rcmd_len  input  LenWidth  read beats minus one.
- i_umai_wvalid  input  1  write data valid.
- o_umai_wready  output  1  write data accepted.
- i_umai_wdata  input  DataWidth  write data beat.
- o_umai_rvalid  output  1  read data valid.
- i_umai_rready  input  1  read data accepted.
- o_umai_rdata  output  DataWidth  read data beat.
- o_busy  output  1  FSM not IDLE, or rvalid high.
- o_wcmd_cnt  output  CntWidth  accepted write commands, saturating.
- o_rcmd_cnt  output  CntWidth  accepted read commands, saturating.

Behaviour:
- Clock and reset: single clock i_clk; asynchronous active-low reset i_rst_n.
- Reset values: FSM=IDLE, all readies 0 except as decoded from IDLE, rvalid=0, rdata=0, counters=0, last_grant=READ. Memory array is not reset.
- Handshake: a transfer occurs on valid&&ready at a rising edge. Burst length = len+1 beats (1..2^LenWidth).
- FSM states IDLE, WRITE, READ. Only one command is active at a time.
- IDLE arbitration:
  - wcmd_ready=1 iff wcmd_valid && (!rcmd_valid || last_grant==READ).
  - rcmd_ready=1 iff rcmd_valid && (!wcmd_valid || last_grant==WRITE).
  - Ready is a combinational function of valid in IDLE; it is 0 in every other state.
  - On acceptance: latch base address (low log2(Depth) bits) and len, clear beat counter, set last_grant, go to WRITE/READ, increment the matching counter (held at all-ones once reached).
- WRITE:
  - wready=1. Each wvalid beat writes mem[(base+beat) mod Depth] and increments beat.
  - Beat with beat==len returns to IDLE next cycle.
  - wvalid while not in WRITE is not accepted (wready=0).
- READ:
  - Beat issue condition: slot_free = !rvalid || rready.
  - When slot_free: rdata <= mem[(base+beat) mod Depth], rvalid <= 1, beat++.
  - Issuing beat==len returns to IDLE; the last beat may still be held in the output register.
  - Outside READ, rvalid clears on rready.
  - Latency: rcmd accepted in cycle N → first rvalid in N+1. Full throughput of one beat per cycle with rready held high.
  - rdata is stable while rvalid && !rready.
- Address wrap: the index wraps modulo Depth within a burst; upper address bits are ignored.
- Read-after-write: data written by a completed write is visible to any later read. Overlapping is impossible because of single-command sequencing.
- Reset mid-burst: the burst is abandoned and the FSM returns to IDLE; memory contents written so far are retained.
- Counters never wrap.

Test Plan:
- Write 4 beats at addr 0x10 (data 0xA0..0xA3), then read len=3 addr 0x10 with rready=1 → rvalid in cycle after rcmd accept; rdata 0xA0,0xA1,0xA2,0xA3 on consecutive cycles; o_wcmd_cnt=1, o_rcmd_cnt=1.
- Depth=64: write len=3 at addr 62 → entries 62,63,0,1 written; read len=1 at addr 0x40 → returns beats 3 and 4 of that write (upper bits ignored).
- wcmd_valid and rcmd_valid both asserted in IDLE, three times in a row → grants W,R,W; rcmd_ready and wcmd_ready never high in the same cycle.
- Read len=7 with rready toggling 1,0,0,1,… → each beat held stable while rready=0, all 8 beats returned in order, none lost or duplicated.
- Write len=63 (64 beats, maximum) → exactly 64 wready handshakes, then IDLE; 65th wvalid sees wready=0.
- Assert i_rst_n=0 after beat 2 of a len=5 write → all outputs at reset values immediately. After release, read len=1 at base → first two beats retained; o_wcmd_cnt=0.
